// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative restoring divider: one quotient bit per clock, WIDTH+1 cycles
//   from the first sampled valid to ready. Results follow RISC-V DIV[U]/REM[U]
//   rules, including divide-by-zero (quo = all ones, rem = a) and signed
//   overflow (most-negative / -1 gives quo = a, rem = 0).
//
//   Optional feature macro: DIVIDER_SIGNED_EN
//     defined     : sign = 1 selects signed two's-complement division
//     not defined : sign is ignored, every operation is unsigned
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   a      in   dividend  [WIDTH-1:0]
//   b      in   divisor   [WIDTH-1:0]
//   sign   in   1 = signed division (signed build only)
//   valid  in   request, held high until the result has been consumed
//   ready  out  quo/rem hold a valid result
//   quo    out  quotient  [WIDTH-1:0]
//   rem    out  remainder [WIDTH-1:0]
// -----------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    input  logic             valid,
    output logic             ready,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_prem;     // partial remainder
    logic [WIDTH-1:0] r_shift;    // dividend bits out at the top, quotient bits in at the bottom
    logic [WIDTH-1:0] r_bmag;
    logic             r_quo_neg;
    logic             r_rem_neg;
    logic             r_ready;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;

    // Operand conditioning at load time
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic             w_quo_neg;
    logic             w_rem_neg;

`ifdef DIVIDER_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        w_a_neg   = sign & a[WIDTH-1];
        w_b_neg   = sign & b[WIDTH-1];
        w_amag    = w_a_neg ? -a : a;
        w_bmag    = w_b_neg ? -b : b;
        // Divide-by-zero keeps the raw all-ones quotient; the remainder still
        // gets the dividend's sign so that rem = -|a| = a.
        w_quo_neg = (w_a_neg ^ w_b_neg) & (|b);
        w_rem_neg = w_a_neg;
    end
`else
    logic w_sign_unused;

    // sign has no effect in the unsigned build; it stays on the port list so
    // instantiations are identical in both builds.
    assign w_sign_unused = sign & 1'b0;

    always_comb begin
        w_amag    = a;
        w_bmag    = b;
        w_quo_neg = w_sign_unused;
        w_rem_neg = w_sign_unused;
    end
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor magnitude.
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_next_prem;

    always_comb begin
        w_shifted   = {r_prem, r_shift[WIDTH-1]};
        w_trial     = w_shifted - {1'b0, r_bmag};
        w_ge        = (w_shifted >= {1'b0, r_bmag});
        // The kept value is always below |b| (or equals the dividend prefix
        // when b = 0), so it fits back into WIDTH bits.
        w_next_prem = w_ge ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        // A low valid aborts anything in flight exactly like reset does.
        if (!rst_n || !valid) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_prem    <= '0;
                    r_shift   <= w_amag;
                    r_bmag    <= w_bmag;
                    r_quo_neg <= w_quo_neg;
                    r_rem_neg <= w_rem_neg;
                    r_cnt     <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    r_prem  <= w_next_prem;
                    r_shift <= {r_shift[WIDTH-2:0], w_ge};
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE edge applies sign correction and publishes;
                    // afterwards the outputs simply hold while valid stays high.
                    if (!r_ready) begin
                        r_quo   <= r_quo_neg ? -r_shift : r_shift;
                        r_rem   <= r_rem_neg ? -r_prem  : r_prem;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign quo   = r_quo;
    assign rem   = r_rem;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider (WIDTH = 32). A table of directed vectors,
//   hand-written abort / reset / operand-change sequences, and randomized
//   operations compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_divider;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         sign  = 1'b0;
    logic         valid = 1'b0;
    logic         ready;
    logic [W-1:0] quo;
    logic [W-1:0] rem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divider #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .sign (sign),
        .valid(valid),
        .ready(ready),
        .quo  (quo),
        .rem  (rem)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[$];

`ifdef DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: RISC-V DIV[U]/REM[U] from plain arithmetic.
    function automatic void ref_div(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                    input logic is, output logic [W-1:0] q,
                                    output logic [W-1:0] r);
        int sa;
        int sb;
        if (ib == 0) begin
            q = '1;
            r = ia;
        end else if (is && SIGNED_EN) begin
            if (ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) begin
                q = ia;
                r = '0;
            end else begin
                sa = ia;
                sb = ib;
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = ia / ib;
            r = ia % ib;
        end
    endfunction

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
        @(negedge clk);
        a     = ia;
        b     = ib;
        sign  = is;
        valid = 1'b1;
    endtask

    // The first posedge here is the edge that samples valid; latency is the
    // number of further edges until ready is seen high.
    task automatic wait_result(input string name, input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready && lat < W + 8);
        check({name, " latency"}, W'(lat), W'(W + 1));
        check({name, " quo"}, quo, eq);
        check({name, " rem"}, rem, er);
    endtask

    task automatic hold_check(input string name, input logic [W-1:0] eq, input logic [W-1:0] er);
        repeat (3) @(posedge clk);
        #1;
        check({name, " hold ready"}, W'(ready), W'(1));
        check({name, " hold quo"}, quo, eq);
        check({name, " hold rem"}, rem, er);
    endtask

    task automatic release_check(input string name);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, " release ready"}, W'(ready), W'(0));
        check({name, " release quo|rem"}, quo | rem, '0);
    endtask

    initial begin
        #5ms;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        // ---------------- directed table ----------------
        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2});
        vecs.push_back('{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1});
        vecs.push_back('{32'd9,          32'd3,          1'b0, 32'd3,          32'd0});
        vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0});
        vecs.push_back('{32'd5,          32'd7,          1'b0, 32'd0,          32'd5});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000});
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1});
        vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF});
`else
        // sign is ignored without the signed build
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000});
`endif

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", W'(ready), W'(0));
        check("reset quo", quo, '0);
        check("reset rem", rem, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
            hold_check($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
            release_check($sformatf("vec%0d", i));
        end

        // ---------------- abort by dropping valid mid-RUN ----------------
        start_op(32'd100, 32'd7, 1'b0);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort ready", W'(ready), W'(0));
        check("abort quo|rem", quo | rem, '0);
        start_op(32'd9, 32'd3, 1'b0);
        wait_result("after abort", 32'd3, 32'd0);
        release_check("after abort");

        // ---------------- operand change mid-RUN is ignored ----------------
        start_op(32'd1000, 32'd10, 1'b0);
        fork
            begin
                repeat (6) @(negedge clk);
                a    = 32'd7;
                b    = 32'd1;
                sign = 1'b1;
            end
        join_none
        wait_result("operand change", 32'd100, 32'd0);
        release_check("operand change");

        // ---------------- reset pulse mid-RUN with valid held ----------------
        start_op(32'd100, 32'd7, 1'b0);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst mid-run ready", W'(ready), W'(0));
        check("rst mid-run quo|rem", quo | rem, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_result("rst mid-run restart", 32'd14, 32'd2);

        // ---------------- reset pulse while holding a result ----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst in done ready", W'(ready), W'(0));
        check("rst in done quo|rem", quo | rem, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_result("rst in done restart", 32'd14, 32'd2);
        release_check("rst in done restart");

        // ---------------- randomized against the reference model ----------------
        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(0, 15);
                2: rb = $urandom >> $urandom_range(0, 31);
                default: begin
                    case ($urandom_range(0, 2))
                        0: rb = 32'd0;
                        1: rb = 32'hFFFF_FFFF;
                        default: rb = 32'd1;
                    endcase
                end
            endcase
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, eq, er);
            start_op(ra, rb, rs);
            wait_result($sformatf("rand%0d a=%h b=%h s=%0d", n, ra, rb, rs), eq, er);
            release_check($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
